// File: rtl/dbg_capture_core.sv
// rtl/dbg_capture_core.sv - probe capture engine: masked value/edge trigger, pre-trigger window, streamed readout
// Optional build macro DBG_CAP_QUALIFY_EN adds a qual input; unqualified cycles are invisible to the capture.
module dbg_capture_core #(
  parameter int DATA_W   = 49,
  parameter int DEPTH    = 1024,
  parameter int PRE_TRIG = 256
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [DATA_W-1:0] probe,
`ifdef DBG_CAP_QUALIFY_EN
  input  logic              qual,
`endif
  input  logic              arm,
  input  logic              stop,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic              trig_mode,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              done,
  output logic              trig_seen
);

  localparam int AW     = $clog2(DEPTH);
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [AW-1:0] PRE_W     = AW'(PRE_TRIG);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LAST_IDX  = (AW+1)'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT_TRIG,
    S_POST,
    S_DONE,
    S_READ
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [AW-1:0]       trig_ptr_q, trig_ptr_d;
  logic                trig_seen_q, trig_seen_d;
  logic                match_prev_q, match_prev_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         iss_cnt_q, iss_cnt_d;
  logic                pend_q, pend_d;
  logic                pend_last_q, pend_last_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_last_q, rd_last_d;
  logic                skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic                skid_last_q, skid_last_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   ram_rd_q;

  logic                qual_w;
  logic                match;
  logic                hit;
  logic                wr_en;
  logic                start;
  logic                rd_phase;
  logic                rd_issue;
  logic                pop;
  logic [1:0]          occ;
  logic [AW-1:0]       rd_addr;

`ifdef DBG_CAP_QUALIFY_EN
  assign qual_w = qual;
`else
  assign qual_w = 1'b1;
`endif

  assign match = ((probe ^ trig_value) & trig_mask) == '0;
  assign hit   = trig_mode ? (match & ~match_prev_q) : match;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    trig_ptr_d   = trig_ptr_q;
    trig_seen_d  = trig_seen_q;
    match_prev_d = match_prev_q;
    rd_ptr_d     = rd_ptr_q;
    iss_cnt_d    = iss_cnt_q;
    pend_d       = 1'b0;
    pend_last_d  = pend_last_q;
    rd_valid_d   = rd_valid_q;
    rd_data_d    = rd_data_q;
    rd_last_d    = rd_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    wr_en        = 1'b0;
    start        = 1'b0;
    rd_addr      = rd_ptr_q;
    pop          = rd_valid_q & rd_ready;
    rd_phase     = (state_q == S_DONE) || (state_q == S_READ);

    case (state_q)
      S_IDLE: begin
        if (arm) start = 1'b1;
      end
      S_PREFILL: begin
        if (qual_w) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q + AW'(1);
          if (cnt_q == PRE_LAST) begin
            cnt_d   = '0;
            state_d = S_WAIT_TRIG;
          end
        end
      end
      S_WAIT_TRIG: begin
        if (qual_w) begin
          wr_en        = 1'b1;
          wr_ptr_d     = wr_ptr_q + AW'(1);
          match_prev_d = match;
          if (hit) begin
            trig_ptr_d  = wr_ptr_q;
            trig_seen_d = 1'b1;
            cnt_d       = '0;
            state_d     = (POST_N == 0) ? S_DONE : S_POST;
          end
        end
      end
      S_POST: begin
        if (qual_w) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q + AW'(1);
          if (cnt_q == POST_LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        rd_addr = trig_ptr_q - PRE_W;
        state_d = S_READ;
        if (arm) start = 1'b1;
      end
      S_READ: begin
        if (pop && rd_last_q) state_d = S_IDLE;
        if (arm) start = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Read issue is credit-limited so the out + skid registers never overflow
    occ = {1'b0, rd_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q} - {1'b0, pop};
    rd_issue = rd_phase && (iss_cnt_q != DEPTH_W) && (occ < 2'd2);
    if (rd_issue) begin
      iss_cnt_d   = iss_cnt_q + (AW+1)'(1);
      rd_ptr_d    = rd_addr + AW'(1);
      pend_d      = 1'b1;
      pend_last_d = (iss_cnt_q == LAST_IDX);
    end

    if (!rd_valid_q || pop) begin
      if (skid_valid_q) begin
        rd_valid_d   = 1'b1;
        rd_data_d    = skid_data_q;
        rd_last_d    = skid_last_q;
        skid_valid_d = pend_q;
        skid_data_d  = ram_rd_q;
        skid_last_d  = pend_last_q;
      end else if (pend_q) begin
        rd_valid_d = 1'b1;
        rd_data_d  = ram_rd_q;
        rd_last_d  = pend_last_q;
      end else begin
        rd_valid_d = 1'b0;
      end
    end else if (pend_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_rd_q;
      skid_last_d  = pend_last_q;
    end

    if (start) begin
      state_d      = (PRE_TRIG == 0) ? S_WAIT_TRIG : S_PREFILL;
      wr_ptr_d     = '0;
      cnt_d        = '0;
      trig_seen_d  = 1'b0;
      match_prev_d = 1'b0;
    end

    if (stop) state_d = S_IDLE;

    // Leaving the readout phase discards anything still in the read pipeline
    if (state_d != S_DONE && state_d != S_READ) begin
      iss_cnt_d    = '0;
      pend_d       = 1'b0;
      rd_valid_d   = 1'b0;
      rd_last_d    = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      trig_ptr_q   <= '0;
      trig_seen_q  <= 1'b0;
      match_prev_q <= 1'b0;
      rd_ptr_q     <= '0;
      iss_cnt_q    <= '0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_last_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      trig_ptr_q   <= trig_ptr_d;
      trig_seen_q  <= trig_seen_d;
      match_prev_q <= match_prev_d;
      rd_ptr_q     <= rd_ptr_d;
      iss_cnt_q    <= iss_cnt_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      rd_last_q    <= rd_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
    end
  end

  // Sample buffer: no reset so it maps onto block RAM
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_ptr_q] <= probe;
    ram_rd_q <= mem[rd_addr];
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign busy      = (state_q == S_PREFILL) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
  assign done      = (state_q == S_DONE) || (state_q == S_READ);
  assign trig_seen = trig_seen_q;

endmodule

// File: tb/tb_dbg_capture_core.sv
// tb/tb_dbg_capture_core.sv - randomized self-checking bench for dbg_capture_core against a window model
module tb_dbg_capture_core;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PRE   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] probe;
  logic          arm;
  logic          stop;
  logic [DW-1:0] trig_value;
  logic [DW-1:0] trig_mask;
  logic          trig_mode;
  logic          rd_valid;
  logic          rd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          done;
  logic          trig_seen;
`ifdef DBG_CAP_QUALIFY_EN
  logic          qual;
  assign qual = probe[0];
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dbg_capture_core #(.DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .probe      (probe),
`ifdef DBG_CAP_QUALIFY_EN
    .qual       (qual),
`endif
    .arm        (arm),
    .stop       (stop),
    .trig_value (trig_value),
    .trig_mask  (trig_mask),
    .trig_mode  (trig_mode),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .busy       (busy),
    .done       (done),
    .trig_seen  (trig_seen)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic qual_now();
`ifdef DBG_CAP_QUALIFY_EN
    return probe[0];
`else
    return 1'b1;
`endif
  endfunction

  // Free-running probe counter advances once per clock
  task automatic tick();
    @(posedge clk);
    #1;
    probe = probe + 8'd1;
  endtask

  task automatic wait_probe(input logic [7:0] v);
    for (int i = 0; i < 300 && probe != v; i++) tick();
  endtask

  function automatic logic is_match(input logic [7:0] x, input logic [7:0] tv, input logic [7:0] tm);
    return ((x ^ tv) & tm) == 8'd0;
  endfunction

  task automatic capture(input string nm, input logic [7:0] tv, input logic [7:0] tm,
                         input logic md, input int rmode, input int arm_at,
                         output logic [7:0] first_v);
    logic [7:0] hist[$];
    logic [7:0] got[$];
    logic       got_l[$];
    logic       seen_done, fin, stalled, first_valid, h;
    logic [8:0] prev_d;
    int         done_c, k, idx;
    seen_done = 0; fin = 0; stalled = 0; first_valid = 0;
    prev_d = '0; done_c = 0; k = -1; first_v = '0;
    trig_value = tv; trig_mask = tm; trig_mode = md;
    if (arm_at >= 0) wait_probe(8'(arm_at));
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk({nm, "_busy_after_arm"}, busy, 1);
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (!seen_done && done) begin
        seen_done = 1;
        done_c = c;
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_trig_seen_at_done"}, trig_seen, 1);
      end
      if (rd_valid) begin
        if (!first_valid) begin
          first_valid = 1;
          chk({nm, "_valid_latency"}, 64'(c - done_c), 2);
        end
        if (stalled) chk({nm, "_stall_hold"}, {rd_last, rd_data}, prev_d);
      end
      case (rmode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (c % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (rd_valid && rd_ready) begin
        got.push_back(rd_data);
        got_l.push_back(rd_last);
        if (rd_last) fin = 1;
      end
      stalled = rd_valid && !rd_ready;
      prev_d = {rd_last, rd_data};
      if (!seen_done && qual_now()) hist.push_back(probe);
      tick();
    end
    rd_ready = 1'b0;
    chk({nm, "_finished"}, fin, 1);
    chk({nm, "_done_after"}, done, 0);
    chk({nm, "_valid_after"}, rd_valid, 0);
    chk({nm, "_trig_seen_after"}, trig_seen, 1);

    // Reference: first trigger among qualified samples past the pre-fill, window around it
    for (int i = PRE; i < hist.size() && k < 0; i++) begin
      h = is_match(hist[i], tv, tm);
      if (md && i > PRE && is_match(hist[i-1], tv, tm)) h = 0;
      if (h) k = i;
    end
    chk({nm, "_window_known"}, (k >= 0) && (k - PRE + DEPTH <= hist.size()), 1);
    chk({nm, "_count"}, got.size(), DEPTH);
    if (k >= 0) begin
      for (int i = 0; i < got.size() && i < DEPTH; i++) begin
        idx = k - PRE + i;
        if (idx < hist.size()) chk({nm, "_data"}, got[i], hist[idx]);
        chk({nm, "_last"}, got_l[i], i == DEPTH - 1);
      end
    end
    if (got.size() > 0) first_v = got[0];
  endtask

  logic [7:0] fv;
  logic       anyv;

  initial begin
    rst = 1'b1; arm = 1'b0; stop = 1'b0; probe = '0;
    trig_value = '0; trig_mask = '0; trig_mode = 1'b0; rd_ready = 1'b0;
    repeat (3) tick();
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_trig_seen", trig_seen, 0);
    chk("reset_outs", {rd_last, rd_data}, 0);
    rst = 1'b0;
    tick();

`ifndef DBG_CAP_QUALIFY_EN
    capture("t1_level", 8'h20, 8'hFF, 1'b0, 0, 8'h10, fv);
    chk("t1_first", fv, 8'h1C);
    capture("t2_prefill_hit", 8'h11, 8'hFF, 1'b0, 0, 8'h10, fv);
    chk("t2_first", fv, 8'h0D);
    capture("t3_edge", 8'h00, 8'h00, 1'b1, 2, 8'h40, fv);
    chk("t3_first", fv, 8'h41);
    capture("t4_backpressure", 8'h20, 8'hFF, 1'b0, 1, 8'h10, fv);
    chk("t4_first", fv, 8'h1C);
`else
    capture("t6_qualify", 8'h21, 8'hFF, 1'b0, 0, 8'h10, fv);
    chk("t6_first", fv, 8'h19);
`endif

    trig_value = 8'h20; trig_mask = 8'hFF; trig_mode = 1'b0;
    wait_probe(8'h10);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int i = 0; i < 60 && !trig_seen; i++) tick();
    chk("t5_in_post", busy & trig_seen, 1);
    stop = 1'b1; arm = 1'b1;
    tick();
    stop = 1'b0; arm = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_valid", rd_valid, 0);
    rd_ready = 1'b1;
    anyv = 1'b0;
    repeat (30) begin
      anyv = anyv | rd_valid | done | busy;
      tick();
    end
    rd_ready = 1'b0;
    chk("t5_quiet", anyv, 0);
    capture("t5_rearm", 8'h20, 8'hFF, 1'b0, 2, 8'h10, fv);

    arm = 1'b1;
    tick();
    arm = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_state", {done, rd_valid, trig_seen}, 0);

    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(0, 5)) tick();
      capture($sformatf("rnd%0d", r), 8'($urandom), 8'($urandom & $urandom),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), -1, fv);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
